dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory request interface; it is the far end of the load/store bus the core drives.
- Accepts one request at a time and holds a word-addressed RAM.
- Returns a response after a configurable latency with valid/ready backpressure.
- Instantiated beside the core in the simulation top and in later SoC integration; it replaces the ideal zero-latency memory the core has used so far.

---
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind a valid/ready request
// bus, answering each request after a fixed number of wait cycles.
module dmem_responder #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 10,
    parameter int                LATENCY    = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W:0] LO_X = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] HI_X = LO_X + (ADDR_W+1)'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_COMMIT,
        S_RESP
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic                  inr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [3:0]            wstrb_q;
    logic                  rsp_valid_q;
    logic [DATA_W-1:0]     rsp_rdata_q;
    logic                  rsp_err_q;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [ADDR_W:0]       addr_x;
    logic                  in_range;
    logic [ADDR_W-1:0]     offset;
    logic [DEPTH_LOG2-1:0] idx_d;
    logic                  unused_bits;

    // Range check in ADDR_W+1 bits so the upper bound cannot wrap.
    assign addr_x      = {1'b0, req_addr};
    assign in_range    = (addr_x >= LO_X) && (addr_x < HI_X);
    assign offset      = req_addr - BASE_ADDR;
    assign idx_d       = offset[DEPTH_LOG2+1:2];
    assign unused_bits = ^{offset[ADDR_W-1:DEPTH_LOG2+2], offset[1:0]};

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_COMMIT && we_q && inr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        inr_q   <= in_range;
                        idx_q   <= idx_d;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (LATENCY == 0) begin
                            state_q <= S_COMMIT;
                        end else begin
                            cnt_q   <= 4'(LATENCY - 1);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_COMMIT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_COMMIT: begin
                    rsp_rdata_q <= (!we_q && inr_q) ? mem[idx_q] : '0;
                    rsp_err_q   <= !inr_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a flat array memory model.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m [1024];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(10),
        .LATENCY(LAT), .BASE_ADDR(32'h8000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic bail(input string tag);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout", tag);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    endtask

    // Memory is 1024 words of 4 bytes starting at 0x8000_0000.
    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [3:0] st,
                                  output logic [31:0] rd, output logic er);
        longint unsigned a;
        longint unsigned base;
        int idx;
        bit inr;
        a    = 64'(addr);
        base = 64'h8000_0000;
        inr  = (a >= base) && (a < base + 64'd4096);
        idx  = inr ? int'((a - base) / 4) : 0;
        rd   = 32'h0;
        er   = !inr;
        if (inr && !we) rd = mem_m[idx];
        if (inr && we) begin
            for (int i = 0; i < 4; i++) begin
                if (st[i]) mem_m[idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
    endfunction

    // Entered and left just after a falling edge.
    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input int hold, output logic [31:0] rd);
        int n;
        logic [31:0] e_rd;
        logic e_er;
        model(we, addr, wd, st, e_rd, e_er);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = st;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) bail("req_ready");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!rsp_valid) bail("rsp_valid");
        check("latency", 32'(n), 32'(LAT + 1));
        check("rdata", rsp_rdata, e_rd);
        check("err", 32'(rsp_err), 32'(e_er));
        rd = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, e_rd);
            check("hold_err", 32'(rsp_err), 32'(e_er));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 19);
        if (k < 16) return 32'h8000_0000 + 32'(4 * k) + 32'($urandom_range(0, 3));
        if (k == 16) return 32'h8000_0FFC + 32'($urandom_range(0, 3));
        if (k == 17) return 32'h8000_1000 + 32'($urandom_range(0, 255));
        if (k == 18) return 32'h7FFF_FFFC - 32'($urandom_range(0, 255));
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] old;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h8000_0000;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rel_req_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < 16; w++) txn(1'b1, 32'h8000_0000 + 32'(4 * w), $urandom, 4'hF, 0, rd);
        txn(1'b1, 32'h8000_0FFC, $urandom, 4'hF, 0, rd);

        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd);
        check("st_rdata", rd, 32'h0);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd);
        check("ld_full", rd, 32'hDEAD_BEEF);
        txn(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, rd);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd);
        check("ld_partial", rd, 32'hDE22_BE44);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, rd);

        txn(1'b1, 32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 0, rd);
        txn(1'b0, 32'h8000_0014, 32'h0, 4'h0, 0, rd);

        txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, rd);
        txn(1'b1, 32'h8000_1000, 32'hA5A5_A5A5, 4'hF, 0, rd);
        txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, rd);
        txn(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0, rd);

        // Reset one cycle after acceptance drops the store.
        old       = mem_m[8];
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = ~old;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_ready", 32'(req_ready), 32'd0);
            check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd);
        check("rst_no_write", rd, old);

        for (int t = 0; t < 60; t++) begin
            txn(1'($urandom), rand_addr(), $urandom, 4'($urandom),
                $urandom_range(0, 3), rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
